// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs a single-outstanding req/gnt/rvalid
// fetch, and hands words to ID with branch-after-delay-slot and immediate exception redirects.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic        r_kill, w_kill_nxt;
    logic        r_pend_valid, w_pend_valid_nxt;
    logic [31:0] r_pend_pc, w_pend_pc_nxt;
    logic        r_if_valid, w_if_valid_nxt;
    logic [31:0] r_if_pc, r_if_inst;
    logic        w_load;
    logic [31:0] w_seq_pc;

    // r_addr is the address actually on the bus; it can lag r_pc when an
    // exception lands while a request is still waiting for its grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_kill       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'd0;
            r_if_valid   <= 1'b0;
            r_if_pc      <= 32'd0;
            r_if_inst    <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_addr       <= w_addr_nxt;
            r_kill       <= w_kill_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_if_valid   <= w_if_valid_nxt;
            if (w_load) begin
                r_if_pc   <= r_pc;
                r_if_inst <= imem_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_addr_nxt       = r_addr;
        w_kill_nxt       = r_kill;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_pc_nxt    = r_pend_pc;
        w_if_valid_nxt   = r_if_valid;
        w_load           = 1'b0;
        w_seq_pc         = r_pend_valid ? r_pend_pc : r_pc + 32'd4;

        case (r_state)
            S_REQ: begin
                if (imem_gnt) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_addr_nxt  = r_pc;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_load         = 1'b1;
                        w_if_valid_nxt = 1'b1;
                        w_state_nxt    = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (!stall) begin
                    w_pc_nxt         = w_seq_pc;
                    w_addr_nxt       = w_seq_pc;
                    w_pend_valid_nxt = 1'b0;
                    w_if_valid_nxt   = 1'b0;
                    w_state_nxt      = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase

        // A redirect seen in the consume cycle belongs to the instruction just
        // consumed, so it must survive the pend clear above.
        if (redirect_valid) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_pc_nxt    = redirect_pc & 32'hFFFF_FFFC;
        end

        if (exc_valid) begin
            w_pend_valid_nxt = 1'b0;
            w_pend_pc_nxt    = r_pend_pc;
            w_if_valid_nxt   = 1'b0;
            w_load           = 1'b0;
            w_pc_nxt         = EXC_VECTOR;
            case (r_state)
                S_REQ: begin
                    // request cannot be withdrawn; its response is dropped later
                    w_kill_nxt = 1'b1;
                    w_addr_nxt = r_addr;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_kill_nxt  = 1'b0;
                        w_addr_nxt  = EXC_VECTOR;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_kill_nxt  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
                default: begin
                    w_addr_nxt  = EXC_VECTOR;
                    w_state_nxt = S_REQ;
                end
            endcase
        end
    end

    assign imem_req  = resetn && (r_state == S_REQ);
    assign imem_addr = r_addr;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_inst   = r_if_inst;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a small memory responder returns ~addr one
// cycle after each grant; expected PCs/words are hand-computed constants.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    logic        gnt_en;
    logic        rv_block;
    logic        r_mem_pend;
    logic [31:0] r_mem_data;

    int n_chk;
    int n_err;

    if_fetch_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exc_valid     (exc_valid),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: grant combinationally, one response held until delivered
    assign imem_gnt    = gnt_en & imem_req;
    assign imem_rvalid = r_mem_pend & ~rv_block;
    assign imem_rdata  = r_mem_data;

    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            r_mem_pend <= 1'b1;
            r_mem_data <= ~imem_addr;
        end else if (imem_rvalid) begin
            r_mem_pend <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // from a REQ cycle: request, response, present, consume; ends at next REQ
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] inst);
        chk("req", {31'd0, imem_req}, 32'd1);
        chk("addr", imem_addr, addr);
        tick();
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("if_valid", {31'd0, if_valid}, 32'd1);
        chk("if_pc", if_pc, addr);
        chk("if_inst", if_inst, inst);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_err = 0;
        resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        exc_valid = 1'b0; stall = 1'b0; gnt_en = 1'b1; rv_block = 1'b0;
        r_mem_pend = 1'b0; r_mem_data = 32'd0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        #1;

        // straight-line fetch, 3 cycles per instruction
        fetch_one(32'hBFC0_0000, 32'h403F_FFFF);

        // exception while waiting for 0xBFC00004, with a redirect pending
        chk("t4_addr", imem_addr, 32'hBFC0_0004);
        redirect_valid = 1'b1; redirect_pc = 32'h1234_5678; rv_block = 1'b1;
        tick();
        redirect_valid = 1'b0;
        exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0; rv_block = 1'b0;
        #1;
        chk("t4_novalid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("t4_drop", {31'd0, if_valid}, 32'd0);
        fetch_one(32'hBFC0_0380, 32'h403F_FC7F);

        // redirect in WAIT: delay slot first, then the target
        chk("t3_addr", imem_addr, 32'hBFC0_0384);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1003;
        tick();
        redirect_valid = 1'b0;
        chk("t3_valid", {31'd0, if_valid}, 32'd1);
        chk("t3_pc", if_pc, 32'hBFC0_0384);
        chk("t3_inst", if_inst, 32'h403F_FC7B);
        tick();
        chk("t3_target", imem_addr, 32'h8000_1000);

        // stall holds the presented instruction
        tick(); tick();
        chk("t2_pc", if_pc, 32'h8000_1000);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_valid", {31'd0, if_valid}, 32'd1);
            chk("t2_hold_pc", if_pc, 32'h8000_1000);
            chk("t2_hold_inst", if_inst, 32'h7FFF_EFFF);
            chk("t2_noreq", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("t2_next", imem_addr, 32'h8000_1004);

        // exception beats consume in OUT
        tick(); tick();
        chk("t5_pc", if_pc, 32'h8000_1004);
        exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        chk("t5_valid", {31'd0, if_valid}, 32'd0);
        chk("t5_addr", imem_addr, 32'hBFC0_0380);

        // redirect low bits masked, then pc+4 wraps to zero
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        chk("wr_slot", if_pc, 32'hBFC0_0380);
        tick();
        chk("wr_target", imem_addr, 32'hFFFF_FFFC);
        tick(); tick();
        chk("wr_pc", if_pc, 32'hFFFF_FFFC);
        chk("wr_inst", if_inst, 32'h0000_0003);
        tick();
        chk("wr_zero", imem_addr, 32'h0000_0000);

        // reset mid-WAIT, late response after release, grant withheld
        rv_block = 1'b1;
        tick();
        resetn = 1'b0;
        #1;
        chk("t6_req", {31'd0, imem_req}, 32'd0);
        chk("t6_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_pc", if_pc, 32'd0);
        chk("t6_inst", if_inst, 32'd0);
        tick();
        gnt_en = 1'b0; rv_block = 1'b0; resetn = 1'b1;
        #1;
        chk("t6_first", imem_addr, 32'hBFC0_0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_req_hold", {31'd0, imem_req}, 32'd1);
            chk("t6_addr_hold", imem_addr, 32'hBFC0_0000);
            chk("t6_novalid", {31'd0, if_valid}, 32'd0);
        end

        // exception while request is ungranted: old addr kept, response dropped
        exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        chk("ex_req_addr", imem_addr, 32'hBFC0_0000);
        gnt_en = 1'b1;
        tick();
        chk("ex_wait_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("ex_drop_valid", {31'd0, if_valid}, 32'd0);
        fetch_one(32'hBFC0_0380, 32'h403F_FC7F);
        chk("ex_after", imem_addr, 32'hBFC0_0384);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
